cmp_serial_dr: RTL
==================

CMP_SERIAL_DR -- requirements
Module: cmp_serial_dr

Interface
REQ-001 Parameter W, default 8, operand width in bits; SHALL be a multiple of DIGIT.
REQ-002 Parameter DIGIT, default 2, bits compared per scan cycle; legal values 1, 2, 4.
REQ-003 Parameter SIGNED, default 0; 1 selects two's-complement compare.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 reset_not  input  1  asynchronous, active-low reset.
REQ-006 go  input  1  request; four-phase handshake with done.
REQ-007 a_1, a_0  input  W  dual-rail operand A; per bit, 10=1, 01=0, 00=spacer, 11=invalid.
REQ-008 b_1, b_0  input  W  dual-rail operand B, same encoding.
REQ-009 gt_1, gt_0, eq_1, eq_0, lt_1, lt_0  output  1 each  registered dual-rail result, A>B, A==B, A<B.
REQ-010 done  output  1  result valid; registered.
REQ-011 err  output  1  invalid-code flag; registered.

Function
REQ-012 The block SHALL be a three-state FSM: IDLE, SCAN, DONE.
REQ-013 IDLE outputs: all six result rails 0 (spacer), done=0, err=0.
REQ-014 In IDLE, on an edge with go=1 and every A/B bit pair complete (exactly one rail high), the block SHALL capture both operands and enter SCAN. That edge is the capture edge E0.
REQ-015 In IDLE, with go=1 and any pair 00 and no pair 11, the block SHALL stay in IDLE with outputs unchanged.
REQ-016 In IDLE, with go=1 and any pair 11, the block SHALL enter DONE with err=1, done=1 and all result rails 0.
REQ-017 SCAN SHALL evaluate one DIGIT-bit slice per edge, MSB slice first. N=W/DIGIT slices are evaluated at edges E0+1 .. E0+N.
REQ-018 The running verdict SHALL start as equal. The first slice that differs sets gt or lt. Later slices SHALL NOT change a decided verdict.
REQ-019 With SIGNED=1, the operand MSB SHALL be inverted before comparison.
REQ-020 At edge E0+N the block SHALL enter DONE. It drives exactly one of gt/eq/lt true, the other two false (x_0=1), and sets done=1.
REQ-021 Operand inputs SHALL be ignored from E0 until return to IDLE.
REQ-022 If go falls during SCAN, the scan SHALL still complete.
REQ-023 DONE SHALL hold outputs until go=0 is sampled. On that edge the block SHALL return to IDLE and the outputs SHALL go to spacer. If go is already 0 on entry, DONE lasts exactly one cycle.
REQ-024 A new request SHALL NOT be accepted in the same edge that leaves DONE.

Reset
REQ-025 reset_not=0 SHALL force IDLE immediately, clear operand and verdict registers, drive all result rails 0, done=0 and err=0, independent of clk.
REQ-026 Reset asserted mid-SCAN or in DONE SHALL abort the operation; no partial result is retained.
REQ-027 After reset_not rises, the first request SHALL be accepted on the first qualifying edge.

Configuration
REQ-028 Macro CMP_SERIAL_EARLY_EXIT_EN.
- Defined: SCAN SHALL enter DONE on the edge that evaluates the first differing slice. Latency is 1..N edges after E0.
- Undefined: latency is always exactly N edges after E0.
- Equal operands take N edges in both builds.

Verification (W=8, DIGIT=2, SIGNED=0 unless stated)
REQ-029 A=0x5A, B=0x5A, go=1 -> done rises at E0+4; eq_1=1, gt_0=1, lt_0=1. Drop go -> next edge: all rails 0, done=0.
REQ-030 A=0x80, B=0x7F -> gt_1=1. With SIGNED=1 -> lt_1=1.
REQ-031 A=0xC0, B=0x00 -> gt_1=1, done at E0+1 with CMP_SERIAL_EARLY_EXIT_EN defined, at E0+4 without it.
REQ-032 A bit 3 rails=11, go=1 -> next edge err=1, done=1, all result rails 0. go=0 -> err=0.
REQ-033 B bit 0 rails=00 with go=1 for 3 cycles -> done stays 0. Complete B=0x01 with A=0x00 -> lt_1=1 at E0+4.
REQ-034 reset_not pulsed low at E0+2 -> outputs spacer immediately. Reissue A=0x03, B=0x02 -> gt_1=1 at the new E0+4.

Source files
------------

// File: rtl/cmp_serial_dr.sv
// Serial dual-rail magnitude comparator: scans DIGIT bits per cycle, MSB slice first.
// Optional macro CMP_SERIAL_EARLY_EXIT_EN: finish on the first differing slice.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | outputs at spacer, waiting for go with complete operands
// SCAN  | comparing one slice per edge, verdict latched on first difference
// DONE  | result (or err) held until go is sampled low
module cmp_serial_dr #(
    parameter int W      = 8,
    parameter int DIGIT  = 2,
    parameter int SIGNED = 0
) (
    input  logic         clk,
    input  logic         reset_not,
    input  logic         go,
    input  logic [W-1:0] a_1,
    input  logic [W-1:0] a_0,
    input  logic [W-1:0] b_1,
    input  logic [W-1:0] b_0,
    output logic         gt_1,
    output logic         gt_0,
    output logic         eq_1,
    output logic         eq_0,
    output logic         lt_1,
    output logic         lt_0,
    output logic         done,
    output logic         err
);

    localparam int N  = W / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   a_sh, b_sh, a_sh_nxt, b_sh_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic           gt_q, lt_q, gt_nxt, lt_nxt;
    logic           gt_1_nxt, gt_0_nxt, eq_1_nxt, eq_0_nxt, lt_1_nxt, lt_0_nxt;
    logic           done_nxt, err_nxt;

    logic [W-1:0]     sign_mask;
    logic             pair_bad, pair_ok;
    logic [DIGIT-1:0] a_dig, b_dig;
    logic             slice_gt, slice_lt, decided, last;

    // Flipping the MSB maps two's-complement order onto unsigned order.
    assign sign_mask = (SIGNED != 0) ? (W'(1) << (W - 1)) : '0;
    assign pair_bad  = (|(a_1 & a_0)) | (|(b_1 & b_0));
    assign pair_ok   = (&(a_1 ^ a_0)) & (&(b_1 ^ b_0));
    assign a_dig     = a_sh[W-1 -: DIGIT];
    assign b_dig     = b_sh[W-1 -: DIGIT];
    assign slice_gt  = a_dig > b_dig;
    assign slice_lt  = a_dig < b_dig;
    assign decided   = gt_q | lt_q;
    assign last      = (cnt == '0);

    always_ff @(posedge clk or negedge reset_not) begin
        if (!reset_not) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            cnt   <= '0;
            gt_q  <= 1'b0;
            lt_q  <= 1'b0;
            gt_1  <= 1'b0;
            gt_0  <= 1'b0;
            eq_1  <= 1'b0;
            eq_0  <= 1'b0;
            lt_1  <= 1'b0;
            lt_0  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            a_sh  <= a_sh_nxt;
            b_sh  <= b_sh_nxt;
            cnt   <= cnt_nxt;
            gt_q  <= gt_nxt;
            lt_q  <= lt_nxt;
            gt_1  <= gt_1_nxt;
            gt_0  <= gt_0_nxt;
            eq_1  <= eq_1_nxt;
            eq_0  <= eq_0_nxt;
            lt_1  <= lt_1_nxt;
            lt_0  <= lt_0_nxt;
            done  <= done_nxt;
            err   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        a_sh_nxt  = a_sh;
        b_sh_nxt  = b_sh;
        cnt_nxt   = cnt;
        gt_nxt    = gt_q;
        lt_nxt    = lt_q;
        case (state)
            IDLE: begin
                if (go) begin
                    if (pair_bad) begin
                        state_nxt = DONE;
                    end else if (pair_ok) begin
                        state_nxt = SCAN;
                        a_sh_nxt  = a_1 ^ sign_mask;
                        b_sh_nxt  = b_1 ^ sign_mask;
                        cnt_nxt   = CW'(N - 1);
                        gt_nxt    = 1'b0;
                        lt_nxt    = 1'b0;
                    end
                end
            end
            SCAN: begin
                a_sh_nxt = a_sh << DIGIT;
                b_sh_nxt = b_sh << DIGIT;
                cnt_nxt  = cnt - CW'(1);
                if (!decided) begin
                    gt_nxt = slice_gt;
                    lt_nxt = slice_lt;
                end
                if (last) begin
                    state_nxt = DONE;
                end
`ifdef CMP_SERIAL_EARLY_EXIT_EN
                else if (!decided && (slice_gt || slice_lt)) begin
                    state_nxt = DONE;
                end
`endif
            end
            DONE: begin
                if (!go) begin
                    state_nxt = IDLE;
                    gt_nxt    = 1'b0;
                    lt_nxt    = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are computed for the coming state and registered alongside it.
    always_comb begin
        gt_1_nxt = 1'b0;
        gt_0_nxt = 1'b0;
        eq_1_nxt = 1'b0;
        eq_0_nxt = 1'b0;
        lt_1_nxt = 1'b0;
        lt_0_nxt = 1'b0;
        done_nxt = 1'b0;
        err_nxt  = 1'b0;
        if (state_nxt == DONE) begin
            done_nxt = 1'b1;
            if (state == IDLE) begin
                err_nxt = 1'b1;
            end else if (state == SCAN) begin
                gt_1_nxt = gt_nxt;
                gt_0_nxt = ~gt_nxt;
                lt_1_nxt = lt_nxt;
                lt_0_nxt = ~lt_nxt;
                eq_1_nxt = ~(gt_nxt | lt_nxt);
                eq_0_nxt = gt_nxt | lt_nxt;
            end else begin
                gt_1_nxt = gt_1;
                gt_0_nxt = gt_0;
                eq_1_nxt = eq_1;
                eq_0_nxt = eq_0;
                lt_1_nxt = lt_1;
                lt_0_nxt = lt_0;
                err_nxt  = err;
            end
        end
    end

endmodule
